// File: rtl/lanceur_pkg.sv
// Shared definitions for the dice-roll engine.
// - FaceTable  : face count of each selectable die, in selection order.
// - LimitTable : acceptance bound faces*floor(128/faces) for a 7-bit draw.
// - LfsrTaps   : Galois mask for x^16+x^14+x^13+x^11+1 (right-shifting form).
// - state_e    : roll FSM states.
package lanceur_pkg;

    localparam int unsigned NumDiceMax = 7;

    localparam logic [6:0] FaceTable [NumDiceMax] = '{
        7'd4, 7'd6, 7'd8, 7'd10, 7'd12, 7'd20, 7'd100
    };

    // Draws at or above this bound are rejected so every face keeps equal weight.
    localparam logic [7:0] LimitTable [NumDiceMax] = '{
        8'd128, 8'd126, 8'd128, 8'd120, 8'd120, 8'd120, 8'd100
    };

    localparam logic [15:0] LfsrTaps = 16'hB400;

    typedef enum logic [2:0] {
        StIdle,
        StDraw,
        StReduce,
        StBcd,
        StDone
    } state_e;

endpackage

// File: rtl/lanceur_de_param_if.sv
// Button/result bundle between the board buttons, the dice engine and the
// 7-segment decoders.
// master : board side, drives the buttons and reads the roll outputs.
// slave  : dice engine, reads the buttons and drives the roll outputs.
interface lanceur_de_param_if;

    logic       Inc_Btn;
    logic       Dec_Btn;
    logic       Roll_Btn;
    logic [2:0] dice_sel;
    logic [6:0] faces;
    logic [6:0] result;
    logic [3:0] d_unit;
    logic [3:0] d_diz;
    logic [3:0] d_cent;
    logic       busy;
    logic       valid;

    modport master (
        output Inc_Btn, Dec_Btn, Roll_Btn,
        input  dice_sel, faces, result, d_unit, d_diz, d_cent, busy, valid
    );

    modport slave (
        input  Inc_Btn, Dec_Btn, Roll_Btn,
        output dice_sel, faces, result, d_unit, d_diz, d_cent, busy, valid
    );

endinterface

// File: rtl/detect_front.sv
// Rising-edge detector for one already-synchronised button level.
// Ports: Clk, Rst (synchronous, active high), i_btn level in,
//        o_rise high for the single cycle where i_btn=1 and last cycle was 0.
module detect_front (
    input  logic Clk,
    input  logic Rst,
    input  logic i_btn,
    output logic o_rise
);

    logic r_prev;

    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_prev <= 1'b0;
        end else begin
            r_prev <= i_btn;
        end
    end

    assign o_rise = i_btn & ~r_prev;

endmodule

// File: rtl/lanceur_de_param.sv
// Parametrised dice-roll engine.
// Ports: Clk, Rst (synchronous, active high), bus (slave side of
//        lanceur_de_param_if): Inc/Dec/Roll buttons in; die index, face count,
//        last result, its BCD digits, busy and valid out.
// Buttons select a die (with wrap), a roll draws an unbiased value 1..faces
// from a free-running LFSR, reduces it by repeated subtraction and converts it
// to BCD one step per cycle; outputs only change on publish or selection clear.
module lanceur_de_param
    import lanceur_pkg::*;
#(
    parameter int unsigned NB_DICE     = 7,
    parameter int unsigned DEFAULT_SEL = 1,
    parameter int unsigned LFSR_W      = 16,
    parameter logic [15:0] SEED        = 16'hACE1
) (
    input logic               Clk,
    input logic               Rst,
    lanceur_de_param_if.slave bus
);

    if (NB_DICE < 1 || NB_DICE > NumDiceMax || DEFAULT_SEL >= NB_DICE || LFSR_W != 16)
    begin : g_bad_param
        $error("lanceur_de_param: unsupported parameter set");
    end

    localparam logic [2:0]        SelMax     = 3'(NB_DICE - 1);
    localparam logic [2:0]        SelDefault = 3'(DEFAULT_SEL);
    localparam logic [LFSR_W-1:0] LfsrMask   = LFSR_W'(LfsrTaps);
    // An all-zero LFSR would lock up, so a zero seed is replaced by 1.
    localparam logic [LFSR_W-1:0] SeedEff    = (SEED == 16'h0) ? LFSR_W'(1) : LFSR_W'(SEED);

    logic w_inc_ev, w_dec_ev, w_roll_ev;

    state_e            r_state, w_state_next;
    logic [2:0]        r_sel, w_sel_next;
    logic [LFSR_W-1:0] r_lfsr, w_lfsr_next;
    logic [6:0]        r_work, w_work_next;    // draw, then remainder, then BCD residue
    logic [6:0]        r_value, w_value_next;  // result waiting for publish
    logic [3:0]        r_wcent, w_wcent_next;
    logic [3:0]        r_wdiz, w_wdiz_next;
    logic [3:0]        r_wunit, w_wunit_next;
    logic [6:0]        r_result, w_result_next;
    logic [3:0]        r_cent, w_cent_next;
    logic [3:0]        r_diz, w_diz_next;
    logic [3:0]        r_unit, w_unit_next;
    logic              r_valid, w_valid_next;

    logic [6:0] w_faces;
    logic [7:0] w_limit;

    detect_front u_det_inc (
        .Clk    (Clk),
        .Rst    (Rst),
        .i_btn  (bus.Inc_Btn),
        .o_rise (w_inc_ev)
    );

    detect_front u_det_dec (
        .Clk    (Clk),
        .Rst    (Rst),
        .i_btn  (bus.Dec_Btn),
        .o_rise (w_dec_ev)
    );

    detect_front u_det_roll (
        .Clk    (Clk),
        .Rst    (Rst),
        .i_btn  (bus.Roll_Btn),
        .o_rise (w_roll_ev)
    );

    assign w_faces = FaceTable[r_sel];
    assign w_limit = LimitTable[r_sel];

    always_comb begin
        w_state_next  = r_state;
        w_sel_next    = r_sel;
        w_work_next   = r_work;
        w_value_next  = r_value;
        w_wcent_next  = r_wcent;
        w_wdiz_next   = r_wdiz;
        w_wunit_next  = r_wunit;
        w_result_next = r_result;
        w_cent_next   = r_cent;
        w_diz_next    = r_diz;
        w_unit_next   = r_unit;
        w_valid_next  = r_valid;
        w_lfsr_next   = (r_lfsr >> 1) ^ (r_lfsr[0] ? LfsrMask : '0);

        unique case (r_state)
            StIdle: begin
                // Roll has priority; simultaneous Inc+Dec cancel out.
                if (w_roll_ev) begin
                    w_state_next = StDraw;
                    w_valid_next = 1'b0;
                end else if (w_inc_ev ^ w_dec_ev) begin
                    if (w_inc_ev) begin
                        w_sel_next = (r_sel == SelMax) ? 3'd0 : r_sel + 3'd1;
                    end else begin
                        w_sel_next = (r_sel == 3'd0) ? SelMax : r_sel - 3'd1;
                    end
                    w_valid_next  = 1'b0;
                    w_result_next = '0;
                    w_cent_next   = '0;
                    w_diz_next    = '0;
                    w_unit_next   = '0;
                end
            end
            StDraw: begin
                if ({1'b0, r_lfsr[6:0]} < w_limit) begin
                    w_work_next  = r_lfsr[6:0];
                    w_state_next = StReduce;
                end
            end
            StReduce: begin
                if (r_work >= w_faces) begin
                    w_work_next = r_work - w_faces;
                end else begin
                    w_value_next = r_work + 7'd1;
                    w_work_next  = r_work + 7'd1;
                    w_wcent_next = '0;
                    w_wdiz_next  = '0;
                    w_state_next = StBcd;
                end
            end
            StBcd: begin
                if (r_work >= 7'd100) begin
                    w_work_next  = r_work - 7'd100;
                    w_wcent_next = r_wcent + 4'd1;
                end else if (r_work >= 7'd10) begin
                    w_work_next = r_work - 7'd10;
                    w_wdiz_next = r_wdiz + 4'd1;
                end else begin
                    w_wunit_next = r_work[3:0];
                    w_state_next = StDone;
                end
            end
            StDone: begin
                w_result_next = r_value;
                w_cent_next   = r_wcent;
                w_diz_next    = r_wdiz;
                w_unit_next   = r_wunit;
                w_valid_next  = 1'b1;
                w_state_next  = StIdle;
            end
            default: begin
                w_state_next = StIdle;
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_state  <= StIdle;
            r_sel    <= SelDefault;
            r_lfsr   <= SeedEff;
            r_work   <= '0;
            r_value  <= '0;
            r_wcent  <= '0;
            r_wdiz   <= '0;
            r_wunit  <= '0;
            r_result <= '0;
            r_cent   <= '0;
            r_diz    <= '0;
            r_unit   <= '0;
            r_valid  <= 1'b0;
        end else begin
            r_state  <= w_state_next;
            r_sel    <= w_sel_next;
            r_lfsr   <= w_lfsr_next;
            r_work   <= w_work_next;
            r_value  <= w_value_next;
            r_wcent  <= w_wcent_next;
            r_wdiz   <= w_wdiz_next;
            r_wunit  <= w_wunit_next;
            r_result <= w_result_next;
            r_cent   <= w_cent_next;
            r_diz    <= w_diz_next;
            r_unit   <= w_unit_next;
            r_valid  <= w_valid_next;
        end
    end

    assign bus.dice_sel = r_sel;
    assign bus.faces    = w_faces;
    assign bus.result   = r_result;
    assign bus.d_unit   = r_unit;
    assign bus.d_diz    = r_diz;
    assign bus.d_cent   = r_cent;
    assign bus.busy     = (r_state != StIdle);
    assign bus.valid    = r_valid;

endmodule

// File: tb/tb_lanceur_de_param.sv
// Scoreboard bench for lanceur_de_param. Two instances: u_dut1 with default
// parameters, u_dut2 on d100 with a seed chosen so its first draw gives 100.
module tb_lanceur_de_param;

    typedef struct {
        int faces;
        int exact;   // 0: any legal value accepted
        bit tally;   // add to the d6 histogram
    } exp_t;

    logic clk = 1'b0;
    logic rst1, rst2;
    always #5 clk = ~clk;

    lanceur_de_param_if bus1 ();
    lanceur_de_param_if bus2 ();

    lanceur_de_param u_dut1 (
        .Clk (clk),
        .Rst (rst1),
        .bus (bus1)
    );

    // Seed 0x24C6 steps to 0x1263, whose low 7 bits are 99 -> result 100.
    lanceur_de_param #(
        .NB_DICE     (7),
        .DEFAULT_SEL (6),
        .LFSR_W      (16),
        .SEED        (16'h24C6)
    ) u_dut2 (
        .Clk (clk),
        .Rst (rst2),
        .bus (bus2)
    );

    int   total = 0;
    int   bad   = 0;
    exp_t q1[$];
    exp_t q2[$];
    int   hist[0:127];

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    task automatic chk_range(input string name, input int act, input int lo, input int hi);
        total++;
        if (act < lo || act > hi) begin
            bad++;
            $display("FAIL %s: got %0d, want %0d..%0d", name, act, lo, hi);
        end
    endtask

    task automatic check_roll(input string tag, input exp_t e, input int res, input int cent,
                              input int diz, input int unit, input int busy);
        chk_range({tag, "_result_range"}, res, 1, e.faces);
        chk({tag, "_bcd_sum"}, 100 * cent + 10 * diz + unit, res);
        chk({tag, "_busy_at_valid"}, busy, 0);
        if (e.exact != 0) begin
            chk({tag, "_exact_result"}, res, e.exact);
            chk({tag, "_exact_cent"}, cent, e.exact / 100);
            chk({tag, "_exact_diz"}, diz, (e.exact / 10) % 10);
            chk({tag, "_exact_unit"}, unit, e.exact % 10);
        end
    endtask

    // Monitors: one pop per rising edge of valid.
    logic v1_q = 1'b0;
    logic v2_q = 1'b0;
    exp_t e1, e2;

    always @(negedge clk) begin
        if (bus1.valid && !v1_q) begin
            if (q1.size() == 0) begin
                total++;
                bad++;
                $display("FAIL dut1_unexpected_valid: got result %0d, want no valid", bus1.result);
            end else begin
                e1 = q1.pop_front();
                check_roll("dut1", e1, int'(bus1.result), int'(bus1.d_cent), int'(bus1.d_diz),
                           int'(bus1.d_unit), int'(bus1.busy));
                if (e1.tally) hist[bus1.result]++;
            end
        end
        v1_q <= bus1.valid;
    end

    always @(negedge clk) begin
        if (bus2.valid && !v2_q) begin
            if (q2.size() == 0) begin
                total++;
                bad++;
                $display("FAIL dut2_unexpected_valid: got result %0d, want no valid", bus2.result);
            end else begin
                e2 = q2.pop_front();
                check_roll("dut2", e2, int'(bus2.result), int'(bus2.d_cent), int'(bus2.d_diz),
                           int'(bus2.d_unit), int'(bus2.busy));
            end
        end
        v2_q <= bus2.valid;
    end

    task automatic wait_idle(input int which, input int limit);
        int n = 0;
        while (((which == 1) ? bus1.busy : bus2.busy) && n < limit) begin
            @(negedge clk);
            n++;
        end
        chk($sformatf("dut%0d_roll_timeout", which),
            int'((which == 1) ? bus1.busy : bus2.busy), 0);
    endtask

    // One-cycle pulse on dut1: 0=inc, 1=dec, 2=inc+dec.
    task automatic pulse1(input int kind);
        bus1.Inc_Btn = (kind == 0 || kind == 2);
        bus1.Dec_Btn = (kind == 1 || kind == 2);
        @(negedge clk);
        bus1.Inc_Btn = 1'b0;
        bus1.Dec_Btn = 1'b0;
        @(negedge clk);
    endtask

    task automatic roll1(input int faces, input bit tally);
        q1.push_back('{faces: faces, exact: 0, tally: tally});
        bus1.Roll_Btn = 1'b1;
        @(negedge clk);
        bus1.Roll_Btn = 1'b0;
        wait_idle(1, 200);
        repeat ($urandom_range(0, 3)) @(negedge clk);
    endtask

    task automatic chk_sel1(input string name, input int sel, input int faces);
        chk({name, "_sel"}, int'(bus1.dice_sel), sel);
        chk({name, "_faces"}, int'(bus1.faces), faces);
    endtask

    initial begin
        for (int i = 0; i < 128; i++) hist[i] = 0;
        rst1 = 1'b1;
        rst2 = 1'b1;
        bus1.Inc_Btn = 1'b0; bus1.Dec_Btn = 1'b0; bus1.Roll_Btn = 1'b0;
        bus2.Inc_Btn = 1'b0; bus2.Dec_Btn = 1'b0; bus2.Roll_Btn = 1'b0;
        repeat (2) @(negedge clk);

        // Reset state
        chk_sel1("reset", 1, 6);
        chk("reset_result", int'(bus1.result), 0);
        chk("reset_digits", int'({bus1.d_cent, bus1.d_diz, bus1.d_unit}), 0);
        chk("reset_busy", int'(bus1.busy), 0);
        chk("reset_valid", int'(bus1.valid), 0);
        rst1 = 1'b0;
        @(negedge clk);

        // Selection and wrap
        repeat (6) pulse1(0);
        chk_sel1("inc_wrap", 0, 4);
        pulse1(1);
        chk_sel1("dec_wrap", 6, 100);
        pulse1(2);
        chk_sel1("inc_dec_same", 6, 100);
        bus1.Inc_Btn = 1'b1;
        repeat (40) @(negedge clk);
        chk_sel1("inc_held", 0, 4);
        bus1.Inc_Btn = 1'b0;
        @(negedge clk);
        pulse1(1);
        chk_sel1("back_to_d100", 6, 100);

        // d100 roll
        q1.push_back('{faces: 100, exact: 0, tally: 1'b0});
        bus1.Roll_Btn = 1'b1;
        @(negedge clk);
        bus1.Roll_Btn = 1'b0;
        chk("roll_busy_rise", int'(bus1.busy), 1);
        wait_idle(1, 200);
        chk("roll_valid", int'(bus1.valid), 1);

        // Busy protection: Inc and Roll during a roll are dropped
        q1.push_back('{faces: 100, exact: 0, tally: 1'b0});
        bus1.Roll_Btn = 1'b1;
        @(negedge clk);
        bus1.Roll_Btn = 1'b0;
        bus1.Inc_Btn  = 1'b1;
        @(negedge clk);
        bus1.Inc_Btn  = 1'b0;
        bus1.Roll_Btn = 1'b1;
        @(negedge clk);
        bus1.Roll_Btn = 1'b0;
        wait_idle(1, 200);
        chk_sel1("busy_drop", 6, 100);
        chk("busy_valid", int'(bus1.valid), 1);
        repeat (5) @(negedge clk);

        // Selection clears the published roll on the next cycle
        bus1.Inc_Btn = 1'b1;
        @(negedge clk);
        chk("clear_valid", int'(bus1.valid), 0);
        chk("clear_result", int'(bus1.result), 0);
        chk("clear_digits", int'({bus1.d_cent, bus1.d_diz, bus1.d_unit}), 0);
        chk_sel1("clear", 0, 4);
        bus1.Inc_Btn = 1'b0;
        @(negedge clk);

        // Distribution on d6
        pulse1(0);
        chk_sel1("to_d6", 1, 6);
        for (int i = 0; i < 3000; i++) roll1(6, 1'b1);
        @(negedge clk);
        for (int f = 1; f <= 6; f++) chk_range($sformatf("d6_count_%0d", f), hist[f], 400, 600);
        chk("d6_count_sum", hist[1] + hist[2] + hist[3] + hist[4] + hist[5] + hist[6], 3000);

        // d20 range
        repeat (4) pulse1(0);
        chk_sel1("to_d20", 5, 20);
        for (int i = 0; i < 2000; i++) roll1(20, 1'b0);

        // dut2: reset while the FSM is in REDUCE
        @(negedge clk);
        rst2 = 1'b0;
        bus2.Roll_Btn = 1'b1;
        @(negedge clk);              // roll event taken, now in DRAW
        bus2.Roll_Btn = 1'b0;
        chk("dut2_busy", int'(bus2.busy), 1);
        @(negedge clk);              // draw accepted, now in REDUCE
        rst2 = 1'b1;
        @(negedge clk);
        chk("midroll_busy", int'(bus2.busy), 0);
        chk("midroll_valid", int'(bus2.valid), 0);
        chk("midroll_result", int'(bus2.result), 0);
        chk("midroll_sel", int'(bus2.dice_sel), 6);
        @(negedge clk);

        // dut2: same seed phase again, roll must publish 100 -> 1/0/0
        q2.push_back('{faces: 100, exact: 100, tally: 1'b0});
        rst2 = 1'b0;
        bus2.Roll_Btn = 1'b1;
        @(negedge clk);
        bus2.Roll_Btn = 1'b0;
        wait_idle(2, 200);
        chk("dut2_valid", int'(bus2.valid), 1);

        repeat (3) @(negedge clk);
        chk("q1_drained", q1.size(), 0);
        chk("q2_drained", q2.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
